// File: rtl/instr_loader.sv
// Instruction loader: receives a framed byte stream from a UART receiver, writes
// the payload words into instruction memory and releases the processor core only
// after the frame checksum has been verified.
//
// Frame: N_lo, N_hi, 4*N payload bytes (little-endian words), checksum byte equal
// to the XOR of every preceding frame byte.
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   rst_i          synchronous active-high reset
//   rx_valid_i     one-cycle strobe, rx_data_i holds a received byte
//   rx_data_i      received byte
//   imem_we_o      instruction-memory write strobe, one cycle per word
//   imem_addr_o    word-aligned byte address of the write
//   imem_wdata_o   instruction word to write
//   core_rst_n_o   active-low core reset, high only after a verified load
//   load_done_o    load completed and checksum matched
//   load_err_o     load aborted (oversize, timeout or checksum mismatch)
//   words_loaded_o number of words written so far
module instr_loader #(
  parameter int unsigned MAX_WORDS      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_wdata_o,
  output logic        core_rst_n_o,
  output logic        load_done_o,
  output logic        load_err_o,
  output logic [15:0] words_loaded_o
);

  typedef enum logic [2:0] {
    StHdr0,
    StHdr1,
    StData,
    StChk,
    StDone,
    StErr
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] word_q, word_d;          // first three bytes of the word in progress
  logic [7:0]  chk_q, chk_d;
  logic [31:0] idle_q, idle_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] words_q, words_d;
  logic [15:0] n_full;
  logic        active;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    chk_d      = chk_q;
    idle_d     = idle_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    words_d    = words_q;
    n_full     = {rx_data_i, n_q[7:0]};
    active     = (state_q == StHdr1) || (state_q == StData) || (state_q == StChk);

    // A byte arriving on the cycle the counter would expire wins over the timeout.
    if (active) begin
      if (rx_valid_i) begin
        idle_d = '0;
      end else begin
        idle_d = idle_q + 32'd1;
        if (idle_d == TIMEOUT_CYCLES) begin
          state_d = StErr;
        end
      end
    end

    if (rx_valid_i) begin
      unique case (state_q)
        StHdr0: begin
          n_d[7:0] = rx_data_i;
          chk_d    = chk_q ^ rx_data_i;
          state_d  = StHdr1;
        end
        StHdr1: begin
          n_d   = n_full;
          chk_d = chk_q ^ rx_data_i;
          if (32'(n_full) > MAX_WORDS) begin
            state_d = StErr;
          end else if (n_full == 16'd0) begin
            state_d = StChk;
          end else begin
            state_d = StData;
          end
        end
        StData: begin
          chk_d      = chk_q ^ rx_data_i;
          byte_cnt_d = byte_cnt_q + 2'd1;
          word_d     = {rx_data_i, word_q[23:8]};
          if (byte_cnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = BASE_ADDR + {14'd0, words_q, 2'b00};
            wdata_d = {rx_data_i, word_q};
            words_d = words_q + 16'd1;
            if (words_d == n_q) begin
              state_d = StChk;
            end
          end
        end
        StChk: begin
          state_d = (rx_data_i == chk_q) ? StDone : StErr;
        end
        default: ;  // DONE and ERR ignore further bytes
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StHdr0;
      n_q        <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      chk_q      <= '0;
      idle_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      chk_q      <= chk_d;
      idle_q     <= idle_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      words_q    <= words_d;
    end
  end

  assign imem_we_o      = we_q;
  assign imem_addr_o    = addr_q;
  assign imem_wdata_o   = wdata_q;
  assign words_loaded_o = words_q;
  assign load_done_o    = (state_q == StDone);
  assign load_err_o     = (state_q == StErr);
  assign core_rst_n_o   = (state_q == StDone);

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed frames plus randomized frames,
// checked against a byte-level frame model.
module tb_instr_loader;

  localparam int unsigned MaxWords = 256;
  localparam int unsigned Timeout  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst_n;
  logic        load_done;
  logic        load_err;
  logic [15:0] words_loaded;

  instr_loader #(
    .MAX_WORDS      (MaxWords),
    .TIMEOUT_CYCLES (Timeout),
    .BASE_ADDR      (32'h0000_0000)
  ) u_dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rx_valid_i     (rx_valid),
    .rx_data_i      (rx_data),
    .imem_we_o      (imem_we),
    .imem_addr_o    (imem_addr),
    .imem_wdata_o   (imem_wdata),
    .core_rst_n_o   (core_rst_n),
    .load_done_o    (load_done),
    .load_err_o     (load_err),
    .words_loaded_o (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observed writes {addr, data}, collected away from the clock edge.
  logic [63:0] obs_q[$];
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      obs_q.push_back({imem_addr, imem_wdata});
      check_eq("words_at_we", 64'(words_loaded), 64'(obs_q.size()));
    end
  end

  // Stimulus since the last reset: byte values and idle cycles before each byte.
  logic [7:0]  byte_q[$];
  int          gap_q[$];
  int          sent;
  logic [63:0] exp_q[$];

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    obs_q.delete();
    byte_q.delete();
    gap_q.delete();
    sent = 0;
    check_eq("rst_we", 64'(imem_we), 64'd0);
    check_eq("rst_addr", 64'(imem_addr), 64'd0);
    check_eq("rst_wdata", 64'(imem_wdata), 64'd0);
    check_eq("rst_core_rst_n", 64'(core_rst_n), 64'd0);
    check_eq("rst_done", 64'(load_done), 64'd0);
    check_eq("rst_err", 64'(load_err), 64'd0);
    check_eq("rst_words", 64'(words_loaded), 64'd0);
  endtask

  task automatic push(input logic [7:0] b, input int gap);
    byte_q.push_back(b);
    gap_q.push_back(gap);
  endtask

  task automatic push_chk(input int gap);
    logic [7:0] x;
    x = 8'h00;
    foreach (byte_q[i]) x ^= byte_q[i];
    push(x, gap);
  endtask

  function automatic int rnd_gap();
    if ($urandom_range(0, 29) == 0) return int'($urandom_range(Timeout - 2, Timeout + 1));
    return int'($urandom_range(0, 2));
  endfunction

  // Frame-level model: walks the byte list and returns the final phase
  // (0 hdr-lo, 1 hdr-hi, 2 payload, 3 checksum, 4 done, 5 error), filling exp_q.
  task automatic model(input int trail, output int st);
    int          n;
    int          pay;
    logic [7:0]  acc;
    logic [31:0] word;
    exp_q.delete();
    st   = 0;
    n    = 0;
    pay  = 0;
    acc  = 8'h00;
    word = 32'h0;
    foreach (byte_q[i]) begin
      if (st >= 4) break;
      if (st >= 1 && gap_q[i] >= int'(Timeout)) begin
        st = 5;
        break;
      end
      case (st)
        0: begin n = int'(byte_q[i]); acc ^= byte_q[i]; st = 1; end
        1: begin
          n   = n + 256 * int'(byte_q[i]);
          acc ^= byte_q[i];
          st  = (n > int'(MaxWords)) ? 5 : ((n == 0) ? 3 : 2);
        end
        2: begin
          acc  ^= byte_q[i];
          word |= 32'(byte_q[i]) << (8 * (pay % 4));
          pay++;
          if (pay % 4 == 0) begin
            exp_q.push_back({32'(4 * (pay / 4 - 1)), word});
            word = 32'h0;
            if (pay == 4 * n) st = 3;
          end
        end
        default: st = (byte_q[i] == acc) ? 4 : 5;
      endcase
    end
    if (st >= 1 && st <= 3 && trail >= int'(Timeout)) st = 5;
  endtask

  // Sends the not-yet-sent bytes, idles, then compares against the model.
  task automatic run(input string tag, input int trail);
    int st;
    for (int i = sent; i < byte_q.size(); i++) begin
      idle(gap_q[i]);
      rx_valid = 1'b1;
      rx_data  = byte_q[i];
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
    end
    sent = byte_q.size();
    idle(trail);
    model(trail, st);
    check_eq({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check_eq({tag, "_write"}, obs_q[i], exp_q[i]);
    end
    check_eq({tag, "_done"}, 64'(load_done), 64'(st == 4));
    check_eq({tag, "_err"}, 64'(load_err), 64'(st == 5));
    check_eq({tag, "_core_rst_n"}, 64'(core_rst_n), 64'(st == 4));
    check_eq({tag, "_words"}, 64'(words_loaded), 64'(exp_q.size()));
    check_eq({tag, "_we_idle"}, 64'(imem_we), 64'd0);
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;

    // Basic load
    do_reset();
    push(8'h01, 0); push(8'h00, 0); push(8'h05, 0); push(8'h00, 0);
    push(8'h10, 0); push(8'h20, 0); push(8'h34, 0);
    run("basic", 2);
    check_eq("basic_word", (obs_q.size() > 0) ? obs_q[0] : 64'd0, {32'h0, 32'h2010_0005});
    check_eq("basic_done_const", 64'(load_done), 64'd1);

    // Bad checksum
    do_reset();
    push(8'h01, 0); push(8'h00, 0); push(8'h05, 0); push(8'h00, 0);
    push(8'h10, 0); push(8'h20, 0); push(8'h35, 0);
    run("badchk", 2);
    check_eq("badchk_err_const", 64'(load_err), 64'd1);

    // Oversize header
    do_reset();
    push(8'h01, 0); push(8'h01, 0);
    run("oversize", 2);
    check_eq("oversize_err_const", 64'(load_err), 64'd1);

    // Timeout, then a byte landing on the last idle cycle
    do_reset();
    push(8'h01, 0); push(8'h00, 0); push(8'h05, 0);
    run("timeout", int'(Timeout));
    check_eq("timeout_err_const", 64'(load_err), 64'd1);
    do_reset();
    push(8'h01, 0); push(8'h00, 0); push(8'h05, 0); push(8'h00, int'(Timeout) - 1);
    push(8'h10, 0); push(8'h20, 0); push(8'h34, 0);
    run("late_byte", 2);

    // Empty load, then bytes after DONE are ignored
    do_reset();
    push(8'h00, 0); push(8'h00, 0); push(8'h00, 0);
    run("empty", 2);
    push(8'h01, 0); push(8'h00, 0); push(8'h05, 0); push(8'h00, 0);
    push(8'h10, 0); push(8'h20, 0); push(8'h34, 0);
    run("after_done", 3);

    // Reset mid-load, then a full two-word frame
    do_reset();
    push(8'h02, 0); push(8'h00, 0); push(8'hAA, 0); push(8'hBB, 0);
    run("partial", 2);
    do_reset();
    push(8'h02, 0); push(8'h00, 1);
    for (int i = 0; i < 8; i++) push(8'(8'h11 * (i + 1)), 0);
    push_chk(0);
    run("midreset", 2);

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      do_reset();
      n = int'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) n = int'($urandom_range(MaxWords + 1, MaxWords + 40));
      if ($urandom_range(0, 9) == 0) n = int'(MaxWords);
      push(8'(n), rnd_gap());
      push(8'(n >> 8), rnd_gap());
      if (n <= int'(MaxWords)) begin
        for (int i = 0; i < 4 * n; i++) push(8'($urandom), rnd_gap());
        push_chk(rnd_gap());
        if ($urandom_range(0, 4) == 0) byte_q[byte_q.size() - 1] ^= 8'(1 << $urandom_range(0, 7));
        if ($urandom_range(0, 5) == 0) begin
          byte_q.pop_back();
          gap_q.pop_back();
        end
      end
      run("rand", ($urandom_range(0, 3) == 0) ? int'(Timeout) : 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter MAX_WORDS, default 256, the maximum instruction words accepted per load.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000, the maximum idle cycles allowed between bytes once a load has started.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000, the instruction-memory byte address of word 0.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 rx_valid  input  1  one-cycle strobe: rx_data holds a received byte from the upstream UART receiver.
REQ-007 rx_data  input  8  received byte; sampled only when rx_valid=1.
REQ-008 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_addr  output  32  word-aligned byte address of the write.
REQ-010 imem_wdata  output  32  instruction word to write.
REQ-011 core_rst_n  output  1  active-low reset to the processor core; 0 holds the core in reset.
REQ-012 load_done  output  1  load completed and checksum matched.
REQ-013 load_err  output  1  load aborted: oversize, timeout or checksum mismatch.
REQ-014 words_loaded  output  16  count of words written so far.

Function
REQ-015 The block SHALL sit upstream of the processor, filling instruction memory from a byte stream and releasing the core only after a verified load.
REQ-016 Frame format SHALL be: N_lo, N_hi (16-bit word count N), then 4*N payload bytes, then one checksum byte.
REQ-017 The checksum SHALL equal the XOR of every preceding frame byte, header included.
REQ-018 The FSM SHALL have states HDR0, HDR1, DATA, CHK, DONE and ERR; reset SHALL enter HDR0.
REQ-019 HDR0 -> HDR1 on rx_valid; HDR1 -> ERR on rx_valid if N > MAX_WORDS, -> CHK if N = 0, else -> DATA.
REQ-020 In DATA, bytes SHALL be packed little-endian: first byte into [7:0], fourth byte into [31:24].
REQ-021 On the cycle after the fourth byte of word k is sampled, imem_we SHALL be 1 for exactly one cycle, with imem_addr = BASE_ADDR + 4*k and imem_wdata = the packed word.
REQ-022 words_loaded SHALL increment in the same cycle that imem_we is asserted; DATA -> CHK after the byte that completes word N-1.
REQ-023 CHK -> DONE on rx_valid with a matching checksum; CHK -> ERR on mismatch.
REQ-024 In DONE, load_done=1 and core_rst_n=1 SHALL hold, starting the cycle after the checksum byte.
REQ-025 In ERR, load_err=1 and core_rst_n=0 SHALL hold.
REQ-026 DONE and ERR SHALL be terminal until rst; rx_valid in these states SHALL be ignored, with no writes and no status change.
REQ-027 The idle counter SHALL clear on every rx_valid and count each cycle in HDR1, DATA and CHK without rx_valid.
REQ-028 When the idle counter reaches TIMEOUT_CYCLES, the FSM SHALL enter ERR. HDR0 has no timeout.
REQ-029 If rx_valid arrives in the cycle the counter would reach TIMEOUT_CYCLES, the byte SHALL win: it is consumed and the counter cleared.
REQ-030 core_rst_n SHALL be 0 in every state except DONE.
REQ-031 imem_we SHALL be 0 whenever the FSM is not completing a word.

Reset
REQ-032 While rst=1 at a clock edge, the block SHALL set: state HDR0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst_n=0, load_done=0, load_err=0, words_loaded=0, checksum accumulator 0, idle counter 0.
REQ-033 rst asserted mid-load SHALL abandon the partial frame with no further writes; after rst deasserts, loading SHALL restart at HDR0, re-asserting core reset even from DONE.

Verification
REQ-034 Basic load: bytes 01 00 05 00 10 20 34 -> one imem_we with addr 0x0 and data 0x20100005; load_done=1, core_rst_n=1, words_loaded=1.
REQ-035 Bad checksum: same frame with last byte 35 -> word written; load_err=1, core_rst_n=0, load_done=0.
REQ-036 Oversize: header 01 01 (N=257) with MAX_WORDS=256 -> ERR after the second byte; no imem_we.
REQ-037 Timeout: with TIMEOUT_CYCLES=16, send 01 00 05 then idle 16 cycles -> load_err=1, no write. Repeat with a byte arriving on the 16th idle cycle -> no error.
REQ-038 Empty load and ignore-after-done: bytes 00 00 00 -> DONE with words_loaded=0. Further bytes -> no imem_we, outputs unchanged.
REQ-039 Mid-load reset: pulse rst after 2 payload bytes, then send a full valid 2-word frame -> exactly two writes at 0x0 and 0x4, then DONE.
